// File: rtl/cpu_writeback_pkg.sv
// Shared opcode header for the CPU pipeline.
// Holds the stage-4 push-control codes (UC_PUSH*), the stack value type tags
// (TYPE_*), and a small decode helper used by the writeback stage.
package cpu_writeback_pkg;

  // Push-control codes carried alongside a stage-4 instruction.
  localparam logic [2:0] UC_PUSHNONE = 3'h0;
  localparam logic [2:0] UC_PUSHALU  = 3'h1;
  localparam logic [2:0] UC_PUSHMEM  = 3'h2;
  localparam logic [2:0] UC_PUSHIMM  = 3'h3;
  localparam logic [2:0] UC_PUSHPC   = 3'h4;

  // Type tags stored in bits [34:32] of every stack entry.
  localparam logic [2:0] TYPE_INT    = 3'h0;
  localparam logic [2:0] TYPE_REF    = 3'h1;
  localparam logic [2:0] TYPE_RETPC  = 3'h2;
  localparam logic [2:0] TYPE_FLOAT  = 3'h3;

  // Any code other than UC_PUSHNONE pushes exactly one entry.
  function automatic logic uc_is_push(input logic [2:0] ctrl);
    return ctrl != UC_PUSHNONE;
  endfunction

endpackage

// File: rtl/cpu_stack_ram.sv
// Operand-stack storage for the writeback stage.
// 2^AddrW entries of DataW bits, one synchronous write port, two asynchronous
// read ports. Contents are not reset; the owner masks stale data by depth.
//   clk_i      write clock
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   raddr_a_i  read port A address, rdata_a_o combinational data
//   raddr_b_i  read port B address, rdata_b_o combinational data
module cpu_stack_ram #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 35
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_a_i,
  output logic [DataW-1:0] rdata_a_o,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [DataW-1:0] rdata_b_o
);

  logic [DataW-1:0] mem_q [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/cpu_writeback.sv
// Stage 5 of the CPU pipeline: commits stack effects and branches.
// Maintains the operand-stack pointer and stack RAM, exposes the top two
// entries and depth to decode, issues a one-cycle redirect on taken branches,
// discards the stack effects of wrong-path instructions for SQUASH_CYCLES
// cycles afterwards, and freezes with a sticky fault on over/underflow.
//   clk, rst                 clock, synchronous active-high reset
//   c__to_push_4a            push control (UC_PUSHNONE = no push)
//   st__to_pop_4a            number of entries to pop
//   st__to_push_4a           tagged value to push {type, data}
//   kill_4a/branch_target_4a taken branch and its target
//   pc_4a                    pc of the stage-4 instruction
//   redirect_valid_5a/_pc_5a one-cycle fetch redirect
//   st__depth_5a             live entry count
//   st__top_5a/st__next_5a   entries at sp-1 / sp-2, zero when absent
//   squashing_5a             squash window active
//   fault_5a/fault_pc_5a     sticky stack fault and faulting pc
module cpu_writeback
  import cpu_writeback_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 10,
  parameter int unsigned SQUASH_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            c__to_push_4a,
  input  logic [10:0]           st__to_pop_4a,
  input  logic [34:0]           st__to_push_4a,
  input  logic                  kill_4a,
  input  logic [31:0]           branch_target_4a,
  input  logic [31:0]           pc_4a,
  output logic                  redirect_valid_5a,
  output logic [31:0]           redirect_pc_5a,
  output logic [DEPTH_LOG2:0]   st__depth_5a,
  output logic [34:0]           st__top_5a,
  output logic [34:0]           st__next_5a,
  output logic                  squashing_5a,
  output logic                  fault_5a,
  output logic [31:0]           fault_pc_5a
);

  localparam int unsigned StackW = 35;
  localparam int unsigned SpW    = DEPTH_LOG2 + 1;
  localparam int unsigned ArithW = DEPTH_LOG2 + 2;
  // The pop count is 11 bits wide, so compare at whichever width is larger
  // to keep a huge pop from aliasing into a small one.
  localparam int unsigned CalcW  = (ArithW > 11) ? ArithW : 11;
  localparam int unsigned SqW    = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;

  localparam logic [CalcW-1:0] Capacity   = CalcW'(1) << DEPTH_LOG2;
  localparam logic [SqW-1:0]   SquashLoad = SqW'(SQUASH_CYCLES);

  logic [SpW-1:0]    sp_q, sp_d;
  logic [SqW-1:0]    squash_q, squash_d;
  logic              fault_q, fault_d;
  logic [31:0]       fault_pc_q, fault_pc_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;

  logic              live;
  logic              push;
  logic [CalcW-1:0]  pop_w, sp_w, base_w, new_w;
  logic              underflow, overflow;

  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic [DEPTH_LOG2-1:0] top_addr, next_addr;
  logic [StackW-1:0]     top_raw, next_raw;

  assign live  = !fault_q && (squash_q == '0);
  assign push  = uc_is_push(c__to_push_4a);

  assign pop_w  = CalcW'(st__to_pop_4a);
  assign sp_w   = CalcW'(sp_q);
  assign base_w = sp_w - pop_w;
  assign new_w  = base_w + CalcW'(push);

  assign underflow = pop_w > sp_w;
  // Only meaningful when there is no underflow, so base_w has not wrapped.
  assign overflow  = new_w > Capacity;

  always_comb begin
    sp_d             = sp_q;
    squash_d         = squash_q;
    fault_d          = fault_q;
    fault_pc_d       = fault_pc_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    ram_we           = 1'b0;

    if (!live) begin
      // Wrong-path or frozen: only the squash counter moves.
      if (squash_q != '0) begin
        squash_d = squash_q - SqW'(1);
      end
    end else if (underflow || overflow) begin
      fault_d    = 1'b1;
      fault_pc_d = pc_4a;
    end else begin
      ram_we = push;
      sp_d   = new_w[SpW-1:0];
      if (kill_4a) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = branch_target_4a;
        squash_d         = SquashLoad;
      end
    end
  end

  // A push lands at base, so pop-n/push-1 overwrites the deepest popped slot.
  assign ram_waddr = base_w[DEPTH_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q             <= '0;
      squash_q         <= '0;
      fault_q          <= 1'b0;
      fault_pc_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      sp_q             <= sp_d;
      squash_q         <= squash_d;
      fault_q          <= fault_d;
      fault_pc_q       <= fault_pc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // At full depth sp wraps to index 0 in the low bits; sp-1 then still
  // addresses the last slot correctly.
  assign top_addr  = sp_q[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
  assign next_addr = sp_q[DEPTH_LOG2-1:0] - DEPTH_LOG2'(2);

  cpu_stack_ram #(
    .AddrW (DEPTH_LOG2),
    .DataW (StackW)
  ) u_stack_ram (
    .clk_i     (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (st__to_push_4a),
    .raddr_a_i (top_addr),
    .rdata_a_o (top_raw),
    .raddr_b_i (next_addr),
    .rdata_b_o (next_raw)
  );

  // Depth masks stale RAM contents, which are never reset.
  assign st__top_5a        = (sp_q >= SpW'(1)) ? top_raw  : '0;
  assign st__next_5a       = (sp_q >= SpW'(2)) ? next_raw : '0;
  assign st__depth_5a      = sp_q;
  assign squashing_5a      = (squash_q != '0);
  assign fault_5a          = fault_q;
  assign fault_pc_5a       = fault_pc_q;
  assign redirect_valid_5a = redirect_valid_q;
  assign redirect_pc_5a    = redirect_pc_q;

endmodule

// File: doc/cpu_writeback.md
# cpu_writeback

Stage 5 of the CPU pipeline. Consumes the memory stage's stack-effect and branch outputs and commits them to architectural state. It maintains the operand-stack pointer and a stack RAM, exposes the top two stack entries and the depth to decode, and issues a one-cycle fetch redirect on taken branches. After a redirect it suppresses the stack effects of wrong-path instructions and raises a sticky fault on stack overflow or underflow.

## Interface
- `DEPTH_LOG2`, 10: stack capacity is 2^DEPTH_LOG2 entries of 35 bits.
- `SQUASH_CYCLES`, 3: number of stage-4 cycles after a taken branch whose effects are discarded.

- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `c__to_push_4a`  in  3  push control. `UC_PUSHNONE` (3'h0) means no push; any other value pushes one entry.
- `st__to_pop_4a`  in  11  unsigned count of entries to pop.
- `st__to_push_4a`  in  35  tagged value to push: {type[2:0], data[31:0]}.
- `kill_4a`  in  1  taken branch.
- `branch_target_4a`  in  32  redirect address. Valid when `kill_4a` is 1.
- `pc_4a`  in  32  pc of the stage-4 instruction.
- `redirect_valid_5a`  out  1  one-cycle fetch redirect pulse.
- `redirect_pc_5a`  out  32  redirect address.
- `st__depth_5a`  out  DEPTH_LOG2+1  current stack pointer (count of live entries).
- `st__top_5a`  out  35  entry at sp-1. Reads 0 when depth < 1.
- `st__next_5a`  out  35  entry at sp-2. Reads 0 when depth < 2.
- `squashing_5a`  out  1  squash window active.
- `fault_5a`  out  1  sticky stack fault.
- `fault_pc_5a`  out  32  pc of the faulting instruction.

## Operation
**Registered state:**
- `sp` (DEPTH_LOG2+1 bits)
- `squash_cnt` (wide enough to hold SQUASH_CYCLES)
- `fault`, `fault_pc`
- `redirect_valid`, `redirect_pc`

**Per cycle, with `rst` = 0:**
- **Live:** the stage-4 input is live when `fault` = 0 and `squash_cnt` = 0.
- **Not live:** the input has no effect except that `squash_cnt` decrements when it is nonzero. `kill_4a` on a squashed input is ignored.
- **Live input, arithmetic:**
  - `push` = (`c__to_push_4a` != `UC_PUSHNONE`).
  - All arithmetic is done at DEPTH_LOG2+2 bits, zero-extended: `base` = sp − pop, `new` = base + push.
- **Underflow:** pop > sp. Set fault, latch `fault_pc` = `pc_4a`. sp, RAM and redirect are unchanged.
- **Overflow:** `new` > 2^DEPTH_LOG2. Same handling as underflow.
- **Otherwise:**
  - If push, write `st__to_push_4a` at RAM[`base`].
  - sp ← `new`.
  - Pop and push in one instruction replaces entries. For example, pop 2 / push 1 writes at sp−2.
- **Live input with `kill_4a` = 1 and no fault:**
  - Apply the stack effect.
  - `redirect_valid` ← 1, `redirect_pc` ← `branch_target_4a`.
  - `squash_cnt` ← SQUASH_CYCLES.
- A faulting branch does not redirect.
- **`redirect_valid`:** cleared every cycle unless set by the above, so it is a single-cycle pulse.
- **`fault`:** once set, the block freezes (no stack updates, no redirects) until `rst`.
- **Outputs:**
  - `st__top_5a` and `st__next_5a` are asynchronous RAM reads addressed from the registered `sp`.
  - `squashing_5a` = (`squash_cnt` != 0).

**Reset values** (apply at the first clk edge with `rst` = 1, including mid-squash or while faulted):
- sp = 0, `squash_cnt` = 0, `fault` = 0, `fault_pc` = 0, `redirect_valid` = 0, `redirect_pc` = 0.
- RAM contents are not reset. Depth 0 masks them.

## Timing
- **Latency:** one cycle. The effect of stage-4 inputs at edge N is visible on all outputs after edge N.
- **Back-to-back pushes:** read-after-write holds, because the RAM write and the sp update commit on the same edge.
- **Redirect:** `redirect_valid_5a` is high for exactly the cycle after the kill edge.
- **Squash window:** `squashing_5a` is high for SQUASH_CYCLES cycles after the kill edge. The first input after the window is live.
- **Boundary cases:**
  - Depth exactly 2^DEPTH_LOG2 is legal.
  - Pop of 0 with no push is a bubble.
  - A push at full depth faults.
  - A pop larger than depth faults even when a push accompanies it.

## Structure
- **Sub-module `cpu_stack_ram`:**
  - 2^DEPTH_LOG2 × 35.
  - One synchronous write port.
  - Two asynchronous read ports.
- **Shared opcode header:**
  - `UC_PUSHNONE` and the other `UC_PUSH*` codes.
  - `TYPE_*` tag constants.
- **This block:** the stack width constant 35 is defined locally.

## Test plan
- **Basic push/pop:** push 0x0_00000011, then 0x1_00000022, then pop 1 with push ALU 0x0_00000033. Expected response:
  - depth 1, 2, 2;
  - top 0x11, 0x22, 0x33;
  - next 0x0, 0x11, 0x11.
- **Taken branch:** kill with target 0x100, followed by 3 pushes and then 1 push. Expected response:
  - redirect pulse of one cycle, `redirect_pc` 0x100;
  - the 3 pushes are ignored;
  - the 4th push commits, depth 1;
  - a kill inside the squash window produces no second redirect.
- **Underflow:** depth 1, pop 2 at pc 0x40. Expected response:
  - `fault_5a` = 1, `fault_pc` 0x40, depth stays 1;
  - a later push is ignored.
- **Overflow:** with DEPTH_LOG2 = 2, 4 pushes then a 5th. Expected response:
  - depth 4 after the 4th push;
  - the 5th push faults and the top entry is unchanged.
- **Reset mid-operation:** assert `rst` for one cycle during the squash window with depth 3 and the fault set. Expected response:
  - next cycle: depth 0, squashing 0, fault 0, top 0;
  - the following push commits immediately.
